// File: rtl/proc_ctrl_pkg.sv
// Shared constants, state encoding and control-word layout for the multicycle sequencer.
package proc_ctrl_pkg;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h1;
  localparam logic [3:0] OP_SW   = 4'h2;
  localparam logic [3:0] OP_BEQ  = 4'h3;
  localparam logic [3:0] OP_J    = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_I   = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_ONE   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       halted;
  } ctrl_word_t;

  // States in which the shared memory is being accessed and mem_ready is awaited.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state (+mem_ready) to datapath control-word map.
// Only FETCH ir_write/pc_write and the MEM_WR retire depend on mem_ready.
import proc_ctrl_pkg::*;

module ctrl_out_decode (
  input  state_t     i_state,
  input  logic       i_mem_ready,
  output ctrl_word_t o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_ONE;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = ALUSRCB_BRIMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
        o_ctrl.retire    = i_mem_ready;
      end
      S_WB_R: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.retire    = 1'b1;
      end
      S_WB_I: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.retire    = 1'b1;
      end
      S_WB_MEM: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.retire     = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = ALUSRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.retire        = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
        o_ctrl.retire    = 1'b1;
      end
      S_HALT: o_ctrl.halted = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH..WB sequencer with memory-ready handshake, timeout, halt and illegal-opcode trap.
// Optional perf counters are built only when PERF_CNT_EN is defined.
// Memory handshake: a request (mem_read/mem_write) is held for as long as the FSM stays in
// FETCH/MEM_RD/MEM_WR; the access completes in the cycle mem_ready=1, and only then does the FSM advance.
import proc_ctrl_pkg::*;

module multicycle_control #(
  parameter int          OPCODE_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int          CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                retire,
  output logic                halted,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    instr_count,
  output logic [3:0]          dbg_state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_illegal, r_bus_err;
  logic              w_illegal_det, w_timeout, w_waiting;
  logic [3:0]        w_op;
  ctrl_word_t        w_ctrl;
  state_t            w_after_retire;
  // The ALU zero flag is consumed by the datapath together with pc_write_cond.
  logic              w_unused_zero;

  assign w_unused_zero  = zero;
  assign w_op           = 4'(opcode);
  assign w_after_retire = run ? S_FETCH : S_IDLE;
  assign w_waiting      = is_wait_state(r_state) && !mem_ready;
  assign w_timeout      = (MEM_TIMEOUT != 0) && w_waiting &&
                          ((32'(r_wait) + 32'd1) == MEM_TIMEOUT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_illegal_det = 1'b0;
    case (r_state)
      S_IDLE:   if (run) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_timeout)      w_state_nxt = S_HALT;
        else if (mem_ready) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (w_op)
          OP_R:                  w_state_nxt = S_EXEC_R;
          OP_LW, OP_SW, OP_ADDI: w_state_nxt = S_EXEC_I;
          OP_BEQ:                w_state_nxt = S_BRANCH;
          OP_J:                  w_state_nxt = S_JUMP;
          OP_HALT:               w_state_nxt = S_HALT;
          default: begin
            w_state_nxt   = S_HALT;
            w_illegal_det = 1'b1;
          end
        endcase
      end
      S_EXEC_R: w_state_nxt = S_WB_R;
      S_EXEC_I: begin
        case (w_op)
          OP_LW:   w_state_nxt = S_MEM_RD;
          OP_SW:   w_state_nxt = S_MEM_WR;
          default: w_state_nxt = S_WB_I;
        endcase
      end
      S_MEM_RD: begin
        if (w_timeout)      w_state_nxt = S_HALT;
        else if (mem_ready) w_state_nxt = S_WB_MEM;
      end
      S_MEM_WR: begin
        if (w_timeout)      w_state_nxt = S_HALT;
        else if (mem_ready) w_state_nxt = w_after_retire;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_state_nxt = w_after_retire;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Wait counter restarts whenever the FSM moves, so each access gets its own budget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if (w_state_nxt != r_state) begin
      r_wait <= '0;
    end else if ((MEM_TIMEOUT != 0) && w_waiting) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_illegal_det) r_illegal <= 1'b1;
      if (w_timeout)     r_bus_err <= 1'b1;
    end
  end

  ctrl_out_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign pc_source     = w_ctrl.pc_source;
  assign ir_write      = w_ctrl.ir_write;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign retire        = w_ctrl.retire;
  assign halted        = w_ctrl.halted;
  assign illegal_op    = r_illegal;
  assign bus_error     = r_bus_err;
  assign dbg_state     = r_state;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_count, r_instr_count;

  // Both counters saturate instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (run && (r_state != S_HALT) && (r_cycle_count != '1))
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      if (w_ctrl.retire && (r_instr_count != '1))
        r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized instruction mix
// against a per-instruction phase model built from the instruction-class rules.
module tb_multicycle_control;

  localparam int TMO = 15;
  localparam int CW  = 16;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Bench-local phase labels (one per cycle-type of the instruction walk).
  localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXR = 3, P_EXI = 4, P_MRD = 5,
                 P_MWR = 6, P_WBR = 7, P_WBI = 8, P_WBM = 9, P_BR = 10, P_J = 11, P_HALT = 12;

  logic          clock = 1'b0;
  logic          reset, run, zero, mem_ready;
  logic [3:0]    opcode;
  logic          pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a, retire, halted;
  logic          illegal_op, bus_error;
  logic [1:0]    pc_source, alu_src_b, alu_op;
  logic [CW-1:0] cycle_count, instr_count;
  logic [3:0]    dbg_state;
  logic [17:0]   obs_ctl;

  int n_checks = 0;
  int n_errors = 0;
  int m_cyc, m_ins;
  bit m_ill, m_bus, last_run;

  always #5 clock = ~clock;

  multicycle_control #(.OPCODE_W(4), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .retire(retire), .halted(halted), .illegal_op(illegal_op),
    .bus_error(bus_error), .cycle_count(cycle_count), .instr_count(instr_count),
    .dbg_state(dbg_state)
  );

  assign obs_ctl = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, retire, halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control word for one cycle of a given phase.
  function automatic logic [17:0] exp_ctl(input int ph, input bit mr);
    logic pcw, pcwc, irw, iod, mrd, mwr, m2r, rdst, rw, asa, ret, hlt;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwc, irw, iod, mrd, mwr, m2r, rdst, rw, asa, ret, hlt} = '0;
    {pcs, asb, aop} = '0;
    case (ph)
      P_FETCH: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      P_DEC:   asb = 2'b11;
      P_EXR:   begin asa = 1; aop = 2'b10; end
      P_EXI:   begin asa = 1; asb = 2'b10; end
      P_MRD:   begin mrd = 1; iod = 1; end
      P_MWR:   begin mwr = 1; iod = 1; ret = mr; end
      P_WBR:   begin rw = 1; rdst = 1; ret = 1; end
      P_WBI:   begin rw = 1; ret = 1; end
      P_WBM:   begin rw = 1; m2r = 1; ret = 1; end
      P_BR:    begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; ret = 1; end
      P_J:     begin pcw = 1; pcs = 2'b10; ret = 1; end
      P_HALT:  hlt = 1;
      default: ;
    endcase
    return {pcw, pcwc, pcs, irw, iod, mrd, mwr, m2r, rdst, rw, asa, asb, aop, ret, hlt};
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs, advance the model.
  task automatic cyc(input int ph, input bit mr, input logic [3:0] op, input bit z,
                     input bit rn, input string tag);
    logic [17:0] e;
    @(negedge clock);
    mem_ready = mr; opcode = op; zero = z; run = rn;
    #1;
    e = exp_ctl(ph, mr);
    check({tag, "_ctl"}, 32'(obs_ctl), 32'(e));
    check({tag, "_illegal"}, 32'(illegal_op), 32'(m_ill));
    check({tag, "_buserr"}, 32'(bus_error), 32'(m_bus));
    check({tag, "_cycles"}, 32'(cycle_count), PERF ? m_cyc : 0);
    check({tag, "_instrs"}, 32'(instr_count), PERF ? m_ins : 0);
    if (rn && ph != P_HALT && m_cyc < 65535) m_cyc++;
    if (e[1]) begin
      if (m_ins < 65535) m_ins++;
      last_run = rn;
    end
  endtask

  function automatic bit rrun(input bit randrun);
    return randrun ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom);
  endfunction

  // Full walk of one non-halting instruction; fw/mw are mem_ready=0 cycles in fetch/memory.
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input bit z,
                           input bit randrun);
    for (int i = 0; i < fw; i++) cyc(P_FETCH, 0, rop(), 1'($urandom), rrun(randrun), "fetch_wait");
    cyc(P_FETCH, 1, rop(), 1'($urandom), rrun(randrun), "fetch");
    cyc(P_DEC, 1'($urandom), op, z, rrun(randrun), "decode");
    case (op)
      4'h0: begin
        cyc(P_EXR, 1'($urandom), op, z, rrun(randrun), "exec_r");
        cyc(P_WBR, 1'($urandom), op, z, rrun(randrun), "wb_r");
      end
      4'h1: begin
        cyc(P_EXI, 1'($urandom), op, z, rrun(randrun), "exec_lw");
        for (int i = 0; i < mw; i++) cyc(P_MRD, 0, op, z, rrun(randrun), "mem_rd_wait");
        cyc(P_MRD, 1, op, z, rrun(randrun), "mem_rd");
        cyc(P_WBM, 1'($urandom), op, z, rrun(randrun), "wb_mem");
      end
      4'h2: begin
        cyc(P_EXI, 1'($urandom), op, z, rrun(randrun), "exec_sw");
        for (int i = 0; i < mw; i++) cyc(P_MWR, 0, op, z, rrun(randrun), "mem_wr_wait");
        cyc(P_MWR, 1, op, z, rrun(randrun), "mem_wr");
      end
      4'h3: cyc(P_BR, 1'($urandom), op, z, rrun(randrun), "branch");
      4'h4: cyc(P_J, 1'($urandom), op, z, rrun(randrun), "jump");
      default: begin
        cyc(P_EXI, 1'($urandom), op, z, rrun(randrun), "exec_addi");
        cyc(P_WBI, 1'($urandom), op, z, rrun(randrun), "wb_i");
      end
    endcase
    if (!last_run) begin
      cyc(P_IDLE, 1'($urandom), rop(), 1'($urandom), 0, "idle_hold");
      cyc(P_IDLE, 1'($urandom), rop(), 1'($urandom), 1, "idle_go");
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1; run = 0;
    #1;
    check("rst_ctl", 32'(obs_ctl), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_flags", 32'({illegal_op, bus_error}), 0);
    check("rst_counts", 32'({cycle_count, instr_count}), 0);
    @(negedge clock);
    reset = 0;
    m_cyc = 0; m_ins = 0; m_ill = 0; m_bus = 0; last_run = 1;
  endtask

  initial begin
    reset = 1; run = 0; zero = 0; mem_ready = 0; opcode = 4'h0;
    m_cyc = 0; m_ins = 0; m_ill = 0; m_bus = 0; last_run = 1;
    #2;
    check("init_ctl", 32'(obs_ctl), 0);
    check("init_state", 32'(dbg_state), 0);
    do_reset();

    // Directed instruction mix with run held high.
    cyc(P_IDLE, 0, 4'h0, 0, 1, "idle_start");
    run_instr(4'h0, 0, 0, 0, 0);
    run_instr(4'h1, 0, 3, 0, 0);
    run_instr(4'h3, 0, 0, 1, 0);
    run_instr(4'h3, 0, 0, 0, 0);
    run_instr(4'h4, 0, 0, 0, 0);
    run_instr(4'h2, 0, TMO - 1, 0, 0);
    run_instr(4'h5, 2, 0, 1, 0);
    run_instr(4'h1, TMO - 1, 0, 0, 0);

    // Randomized legal instruction stream with run dropping at random.
    for (int n = 0; n < 40; n++)
      run_instr(4'($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 4),
                1'($urandom), 1);

    // Asynchronous reset in the middle of EXEC_R.
    cyc(P_FETCH, 1, rop(), 0, 1, "pre_rst_fetch");
    cyc(P_DEC, 1, 4'h0, 0, 1, "pre_rst_decode");
    cyc(P_EXR, 1, 4'h0, 0, 1, "pre_rst_exec");
    #1 reset = 1; run = 0;
    #1;
    check("async_rst_ctl", 32'(obs_ctl), 0);
    check("async_rst_state", 32'(dbg_state), 0);
    check("async_rst_counts", 32'({cycle_count, instr_count}), 0);
    @(negedge clock);
    reset = 0;
    m_cyc = 0; m_ins = 0; m_ill = 0; m_bus = 0; last_run = 1;
    #1 check("post_rst_state", 32'(dbg_state), 0);
    cyc(P_IDLE, 1, 4'h0, 0, 1, "post_rst_idle");
    run_instr(4'h0, 0, 0, 0, 0);

    // Fetch timeout: mem_ready stuck low.
    do_reset();
    cyc(P_IDLE, 0, 4'h0, 0, 1, "tmo_idle");
    for (int i = 0; i < TMO; i++) cyc(P_FETCH, 0, rop(), 0, 1, "tmo_fetch");
    m_bus = 1;
    for (int i = 0; i < 6; i++)
      cyc(P_HALT, 1'($urandom), rop(), 1'($urandom), 1'(i), "tmo_halt");

    // Memory-read timeout: no write-back afterwards.
    do_reset();
    cyc(P_IDLE, 0, 4'h0, 0, 1, "tmo2_idle");
    cyc(P_FETCH, 1, rop(), 0, 1, "tmo2_fetch");
    cyc(P_DEC, 1, 4'h1, 0, 1, "tmo2_decode");
    cyc(P_EXI, 1, 4'h1, 0, 1, "tmo2_exec");
    for (int i = 0; i < TMO; i++) cyc(P_MRD, 0, 4'h1, 0, 1, "tmo2_mem_rd");
    m_bus = 1;
    for (int i = 0; i < 3; i++) cyc(P_HALT, 1, 4'h1, 0, 1, "tmo2_halt");

    // Illegal opcodes: the directed 1010 and one random undefined code.
    for (int k = 0; k < 2; k++) begin
      logic [3:0] bad;
      bad = (k == 0) ? 4'hA : 4'($urandom_range(6, 14));
      do_reset();
      cyc(P_IDLE, 0, 4'h0, 0, 1, "ill_idle");
      cyc(P_FETCH, 1, rop(), 0, 1, "ill_fetch");
      cyc(P_DEC, 1'($urandom), bad, 0, 1, "ill_decode");
      m_ill = 1;
      for (int i = 0; i < 5; i++)
        cyc(P_HALT, 1'($urandom), bad, 1'($urandom), 1'($urandom), "ill_halt");
    end

    // HALT opcode stops without flagging an illegal op.
    do_reset();
    cyc(P_IDLE, 0, 4'h0, 0, 1, "hlt_idle");
    cyc(P_FETCH, 1, rop(), 0, 1, "hlt_fetch");
    cyc(P_DEC, 1, 4'hF, 0, 1, "hlt_decode");
    for (int i = 0; i < 4; i++) cyc(P_HALT, 1'($urandom), 4'hF, 0, 1'($urandom), "hlt_halt");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
